systolic_gemm_sequencer: RTL
============================

// Module: systolic_gemm_sequencer
// PURPOSE
//   Sequences one GEMM tile through the systolic array: accepts a job, streams array_dim weight rows,
//   then array_dim input rows with paired partial-sum rows, waits for drain, and forwards output rows
//   to writeback. Sits between the scratchpad/memory stream ports and the array's memory-side signals.
// PARAMETERS
//   ARRAY_DIM  4   array rows/cols; power of two, >=2
//   DATA_W     16  element width (FP16)
// PORTS
//   CLK             in   1                  clock, rising edge
//   nRST            in   1                  asynchronous, active-low reset
//   start_valid     in   1                  job request
//   start_ready     out  1                  job accepted when valid&ready
//   busy            out  1                  job in flight
//   done            out  1                  1-cycle pulse: tile complete
//   w_valid/w_ready in/out 1                weight row stream handshake
//   w_data          in   DATA_W*ARRAY_DIM   weight row
//   x_valid/x_ready in/out 1                input row stream handshake
//   x_data, ps_data in   DATA_W*ARRAY_DIM   input row, matching partial-sum row
//   sa_weight_en, sa_input_en, sa_partial_en  out 1  array enables
//   sa_row_in_en, sa_row_ps_en  out  $clog2(ARRAY_DIM)  row selects
//   sa_array_in, sa_array_in_partials  out  DATA_W*ARRAY_DIM  row data to array
//   sa_fifo_has_space, sa_drained, sa_out_en  in 1   array status
//   sa_row_out      in   $clog2(ARRAY_DIM)  row index of sa_array_output
//   sa_array_output in   DATA_W*ARRAY_DIM   output row
//   wb_valid        out  1                  output row valid (no backpressure)
//   wb_row          out  $clog2(ARRAY_DIM)  output row index
//   wb_data         out  DATA_W*ARRAY_DIM   output row data
//   row_err         out  1                  sticky: output row out of order
// BEHAVIOUR
//   - Reset: every output 0; state IDLE; counters 0. Reset mid-tile abandons the tile, no done.
//   - FSM: IDLE -> LOAD_W -> LOAD_X -> DRAIN -> IDLE.
//   - IDLE: start_ready = sa_fifo_has_space. Accept -> LOAD_W, busy=1 next cycle.
//   - LOAD_W: w_ready=1. Each accepted beat registers next cycle: sa_weight_en=1,
//     sa_row_in_en=wcnt, sa_array_in=w_data; wcnt++. Beat ARRAY_DIM-1 -> LOAD_X, wcnt=0.
//   - LOAD_X: x_ready = sa_fifo_has_space. Each accepted beat registers next cycle:
//     sa_input_en=sa_partial_en=1, sa_row_in_en=sa_row_ps_en=xcnt, data/partials; xcnt++.
//     Beat ARRAY_DIM-1 -> DRAIN.
//   - Enables are single-cycle per beat; zero when no beat accepted (data regs hold).
//   - Output collection (any non-IDLE state): sa_out_en -> next cycle wb_valid=1,
//     wb_row=sa_row_out, wb_data=sa_array_output; ocnt++. sa_row_out != ocnt sets row_err
//     (cleared only by reset); row still forwarded.
//   - DRAIN: when ocnt==ARRAY_DIM (incl. row arriving this cycle) and sa_drained=1 ->
//     done pulse next cycle, busy=0, IDLE, ocnt=0. Never both w_ready and x_ready high.
//   - Counters are $clog2(ARRAY_DIM)+1 bits; ocnt saturates at ARRAY_DIM, extra rows set row_err.
//   - Latency: accepted row to array pins 1 cycle; sa_out_en to wb_valid 1 cycle.
//   - start_valid ignored while busy; done and start_ready may not overlap (IDLE one cycle later).
// STRUCTURE
//   - Shared package gemm_pkg: typedef enum {IDLE,LOAD_W,LOAD_X,DRAIN} seq_state_t;
//     row_t = logic [DATA_W*ARRAY_DIM-1:0]; default ARRAY_DIM/DATA_W constants.
//   - Single sub-module: gemm_out_collector (ocnt, wb regs, row_err, all_rows_in flag).
//   - FSM, load counters, array-side registers in top.
// TESTING
//   1 Reset: nRST low mid-LOAD_X -> all outputs 0, IDLE, start_ready=sa_fifo_has_space.
//   2 Full tile, ARRAY_DIM=4: 4 W beats back-to-back -> sa_weight_en 4 cycles, row_in_en 0,1,2,3;
//     4 X beats -> input/partial_en with rows 0..3; out rows 0..3 + drained -> one done pulse.
//   3 Backpressure: sa_fifo_has_space=0 in LOAD_X -> x_ready=0, no enables; restore -> resumes at xcnt.
//   4 Gapped streams: w_valid toggling 1/0 -> enables only on accepted beats, row indices contiguous.
//   5 Drain ordering: all 4 out rows but sa_drained=0 for 5 cycles -> no done until drained=1.
//   6 Row error: sa_row_out sequence 0,2,1,3 -> row_err=1 sticky, wb rows forwarded, done still fires.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and default sizing for the GEMM tile sequencer.
package gemm_pkg;

    localparam int ARRAY_DIM_DEF = 4;
    localparam int DATA_W_DEF    = 16;

    // Tile sequencing phases.
    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        DRAIN
    } seq_state_t;

    // One full array row at default sizing.
    typedef logic [DATA_W_DEF*ARRAY_DIM_DEF-1:0] row_t;

endpackage

// File: rtl/gemm_out_collector.sv
// Collects output rows from the systolic array, forwards them to writeback
// one cycle later, tracks the in-order row count and flags out-of-order rows.
module gemm_out_collector
    import gemm_pkg::*;
#(
    parameter int ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              active,
    input  logic                              clear,
    input  logic                              sa_out_en,
    input  logic [$clog2(ARRAY_DIM)-1:0]      sa_row_out,
    input  logic [DATA_W*ARRAY_DIM-1:0]       sa_array_output,
    output logic                              wb_valid,
    output logic [$clog2(ARRAY_DIM)-1:0]      wb_row,
    output logic [DATA_W*ARRAY_DIM-1:0]       wb_data,
    output logic                              row_err,
    output logic                              all_rows_in
);

    localparam int RW = $clog2(ARRAY_DIM);
    localparam int CW = RW + 1;
    localparam logic [CW-1:0] FULL = CW'(ARRAY_DIM);
    localparam logic [CW-1:0] LAST = CW'(ARRAY_DIM - 1);

    logic [CW-1:0]              ocnt;
    logic                       take;
    logic                       full;
    logic                       in_order;
    logic                       vld_p1;
    logic [RW-1:0]              row_p1;
    logic [DATA_W*ARRAY_DIM-1:0] data_p1;

    assign take        = active & sa_out_en;
    assign full        = (ocnt == FULL);
    // A row is in order only if it is the next expected index and the tile
    // is not already complete; surplus rows are errors too.
    assign in_order    = !full && ({1'b0, sa_row_out} == ocnt);
    // Counts a row landing this very cycle so drain can finish without a bubble.
    assign all_rows_in = full | (take & (ocnt == LAST));

    // Output row counter, saturating at ARRAY_DIM, cleared when the tile retires.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ocnt <= '0;
        end else if (clear) begin
            ocnt <= '0;
        end else if (take && !full) begin
            ocnt <= ocnt + 1'b1;
        end
    end

    // Sticky ordering error; only reset clears it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row_err <= 1'b0;
        end else if (take && !in_order) begin
            row_err <= 1'b1;
        end
    end

    // Writeback stage: rows are forwarded even when out of order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_p1  <= 1'b0;
            row_p1  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= take;
            if (take) begin
                row_p1  <= sa_row_out;
                data_p1 <= sa_array_output;
            end
        end
    end

    assign wb_valid = vld_p1;
    assign wb_row   = row_p1;
    assign wb_data  = data_p1;

endmodule

// File: rtl/systolic_gemm_sequencer.sv
// Sequences one GEMM tile through the systolic array: weight rows, then input
// rows with paired partial sums, then waits for all output rows and drain.
module systolic_gemm_sequencer
    import gemm_pkg::*;
#(
    parameter int ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic                              start_valid,
    output logic                              start_ready,
    output logic                              busy,
    output logic                              done,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [DATA_W*ARRAY_DIM-1:0]       w_data,
    input  logic                              x_valid,
    output logic                              x_ready,
    input  logic [DATA_W*ARRAY_DIM-1:0]       x_data,
    input  logic [DATA_W*ARRAY_DIM-1:0]       ps_data,
    output logic                              sa_weight_en,
    output logic                              sa_input_en,
    output logic                              sa_partial_en,
    output logic [$clog2(ARRAY_DIM)-1:0]      sa_row_in_en,
    output logic [$clog2(ARRAY_DIM)-1:0]      sa_row_ps_en,
    output logic [DATA_W*ARRAY_DIM-1:0]       sa_array_in,
    output logic [DATA_W*ARRAY_DIM-1:0]       sa_array_in_partials,
    input  logic                              sa_fifo_has_space,
    input  logic                              sa_drained,
    input  logic                              sa_out_en,
    input  logic [$clog2(ARRAY_DIM)-1:0]      sa_row_out,
    input  logic [DATA_W*ARRAY_DIM-1:0]       sa_array_output,
    output logic                              wb_valid,
    output logic [$clog2(ARRAY_DIM)-1:0]      wb_row,
    output logic [DATA_W*ARRAY_DIM-1:0]       wb_data,
    output logic                              row_err
);

    localparam int RW = $clog2(ARRAY_DIM);
    localparam int CW = RW + 1;
    localparam logic [CW-1:0] LAST = CW'(ARRAY_DIM - 1);

    seq_state_t    state;
    seq_state_t    state_n;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] xcnt;
    logic          w_fire;
    logic          x_fire;
    logic          all_rows_in;
    logic          drain_done;
    logic          collect;

    assign w_fire     = w_valid & w_ready;
    assign x_fire     = x_valid & x_ready;
    assign busy       = (state != IDLE);
    assign collect    = (state != IDLE);
    assign drain_done = (state == DRAIN) & all_rows_in & sa_drained;

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and stream handshakes; start is held off during the done
    // cycle so a new job is never accepted alongside the completion pulse.
    always_comb begin
        state_n     = state;
        start_ready = 1'b0;
        w_ready     = 1'b0;
        x_ready     = 1'b0;
        case (state)
            IDLE: begin
                start_ready = sa_fifo_has_space & ~done;
                if (start_valid && start_ready) begin
                    state_n = LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (wcnt == LAST)) begin
                    state_n = LOAD_X;
                end
            end
            LOAD_X: begin
                x_ready = sa_fifo_has_space;
                if (x_valid && x_ready && (xcnt == LAST)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Weight and input beat counters, wrapping to zero after the last row.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wcnt <= '0;
            xcnt <= '0;
        end else begin
            if (w_fire) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
            end
            if (x_fire) begin
                xcnt <= (xcnt == LAST) ? '0 : xcnt + 1'b1;
            end
        end
    end

    // Array-side registers: enables pulse once per accepted beat, data holds otherwise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sa_weight_en         <= 1'b0;
            sa_input_en          <= 1'b0;
            sa_partial_en        <= 1'b0;
            sa_row_in_en         <= '0;
            sa_row_ps_en         <= '0;
            sa_array_in          <= '0;
            sa_array_in_partials <= '0;
        end else begin
            sa_weight_en  <= w_fire;
            sa_input_en   <= x_fire;
            sa_partial_en <= x_fire;
            if (w_fire) begin
                sa_row_in_en <= wcnt[RW-1:0];
                sa_array_in  <= w_data;
            end else if (x_fire) begin
                sa_row_in_en         <= xcnt[RW-1:0];
                sa_row_ps_en         <= xcnt[RW-1:0];
                sa_array_in          <= x_data;
                sa_array_in_partials <= ps_data;
            end
        end
    end

    // Completion pulse, one cycle after the drain condition is met.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            done <= 1'b0;
        end else begin
            done <= drain_done;
        end
    end

    gemm_out_collector #(
        .ARRAY_DIM (ARRAY_DIM),
        .DATA_W    (DATA_W)
    ) u_out_collector (
        .CLK             (CLK),
        .nRST            (nRST),
        .active          (collect),
        .clear           (drain_done),
        .sa_out_en       (sa_out_en),
        .sa_row_out      (sa_row_out),
        .sa_array_output (sa_array_output),
        .wb_valid        (wb_valid),
        .wb_row          (wb_row),
        .wb_data         (wb_data),
        .row_err         (row_err),
        .all_rows_in     (all_rows_in)
    );

endmodule
